irq_controller: RTL and testbench
=================================

# irq_controller

Machine-level external interrupt controller driving the core's `meip` line and consuming the CSR unit's interrupt acknowledge. It latches rising edges on up to `N_SRC` peripheral interrupt lines, masks them with a software-programmed enable register, and raises `meip_o` while any enabled source is pending. On `ack_i` it claims the highest-priority pending source, records its ID for the handler to read, and holds off further requests until software writes completion. It sits on the peripheral register bus, beside the timer.

## Interface
- `N_SRC`, default 8: number of interrupt sources, range 1..31.
- `clk_i`  in  1: system clock; all logic is rising-edge.
- `reset_i`  in  1: one clock; reset is asynchronous and active-high.
- `irq_i`  in  N_SRC: peripheral interrupt lines, synchronous to `clk_i`; bit 0 has the highest priority.
- `ack_i`  in  1: acknowledge pulse from the CSR unit, high for one cycle when it takes the external interrupt.
- `addr_i`  in  4: register byte address; only `addr_i[3:2]` is decoded.
- `wdata_i`  in  32: write data.
- `wen_i`  in  1: write strobe, one access per cycle.
- `ren_i`  in  1: read strobe.
- `rdata_o`  out  32: read data, registered.
- `meip_o`  out  1: external interrupt request to the CSR unit, registered.

## Operation
- Registers, all bits above `N_SRC` (or above the field) read 0:
  - 0x0 ENABLE (RW). Bit i enables source i.
  - 0x4 PENDING. Read returns the pending latch. Writing 1 to a bit clears it; writing 0 has no effect.
  - 0x8 CLAIM (R). Bits [4:0] hold the claimed ID, which is the source index plus 1; 0 means none. Bit 31 is high while in CLAIMED. Any write while in CLAIMED signals completion; writes in other states are ignored.
  - 0xC reads 0; writes are ignored.
- Edge capture:
  - `irq_prev` holds the previous cycle's `irq_i`.
  - A rising edge (`irq_i & ~irq_prev`) sets the corresponding pending bit.
  - The set has priority over a same-cycle software clear or claim clear of that bit.
  - Disabled sources still latch pending.
- `active = |(pending & enable)`.
- Priority encoder: `win` is the lowest index with `pending & enable` set.
- FSM states: IDLE, ASSERT, CLAIMED.
  - IDLE: if `active`, go to ASSERT. `ack_i` is ignored.
  - ASSERT, on `ack_i`:
    - If `active`: clear `pending[win]`, set CLAIM ID to `win`+1, go to CLAIMED.
    - Otherwise (race): set CLAIM ID to 0, go to IDLE.
  - ASSERT, without `ack_i` and with `!active` (software cleared or disabled everything): go to IDLE.
  - CLAIMED: a write to 0x8 goes to IDLE. CLAIM ID is retained, and bit 31 drops. `ack_i` is ignored. Edges keep latching.
- `meip_o` is registered: it is high in the cycle after the state register becomes ASSERT, and remains high for every cycle the state is ASSERT.
- Read mux is registered: when `ren_i` is high, `rdata_o` is loaded next cycle with the addressed register's value before any same-cycle write. When `ren_i` is low, `rdata_o` holds its value.

## Timing
- Reset values: FSM IDLE; `meip_o`, `rdata_o`, ENABLE, PENDING, CLAIM and `irq_prev` all 0.
- Reset mid-operation immediately deasserts `meip_o` and discards pending and claim state.
- Latency with the source already enabled:
  - Edge on `irq_i` at cycle 0: pending is set at edge 1.
  - State becomes ASSERT at edge 2.
  - `meip_o` goes high at edge 3.
- `ack_i` sampled at edge k: the state leaves ASSERT at k and `meip_o` is low after k+1. This is at most one extra high cycle, which the CSR unit tolerates because it has cleared `mstatus.MIE`.
- Completion write at edge k: state is IDLE at k. If another source is active, ASSERT at k+1 and `meip_o` high at k+2.
- Read: `rdata_o` is valid the cycle after `ren_i`.
- ENABLE write takes effect on `active` the next cycle.

## Test plan
- Reset with `irq_i`=0xFF held: `meip_o`=0, all registers read 0, and after release only the edges arriving post-reset set pending.
- ENABLE=0x04; pulse `irq_i[2]` -> `meip_o`=1 three cycles later. Pulse `ack_i` -> CLAIM reads 0x80000003, PENDING bit 2 = 0, `meip_o`=0. Write 0x8 -> CLAIM reads 0x00000003.
- ENABLE=0xFF; raise bits 5 and 1 in the same cycle; ack -> CLAIM ID 2. Complete -> `meip_o` reasserts; ack -> CLAIM ID 6.
- Pending source 3 with enable 0 -> `meip_o` stays 0. Write ENABLE=0x08 -> `meip_o`=1 two cycles later.
- In ASSERT, write PENDING=0xFF (W1C) -> FSM to IDLE and `meip_o` drops. A late `ack_i` is ignored in IDLE; CLAIM stays 0.
- Rising edge on source 0 in the same cycle as a W1C of bit 0 -> pending bit 0 remains 1.

Source files
------------

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - interrupt lines, CSR acknowledge and register bus of the irq controller
interface irq_controller_if #(
  parameter int N_SRC = 8
);
  logic [N_SRC-1:0] irq_i;
  logic             ack_i;
  logic [3:0]       addr_i;
  logic [31:0]      wdata_i;
  logic             wen_i;
  logic             ren_i;
  logic [31:0]      rdata_o;
  logic             meip_o;

  modport master (
    output irq_i, ack_i, addr_i, wdata_i, wen_i, ren_i,
    input  rdata_o, meip_o
  );

  modport slave (
    input  irq_i, ack_i, addr_i, wdata_i, wen_i, ren_i,
    output rdata_o, meip_o
  );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched, priority-encoded external interrupt controller
// Drives meip to the core and serialises claims until software writes completion.
module irq_controller #(
  parameter int N_SRC = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  irq_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ASSERT, CLAIMED} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] enable_q, pending_q, pending_d, irq_prev_q;
  logic [N_SRC-1:0] masked, sw_clr, claim_clr;
  logic [4:0]       claim_id_q, claim_id_d, win;
  logic             active, wr_enable, wr_pending, wr_claim;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign wr_enable  = bus.wen_i && (bus.addr_i[3:2] == 2'd0);
  assign wr_pending = bus.wen_i && (bus.addr_i[3:2] == 2'd1);
  assign wr_claim   = bus.wen_i && (bus.addr_i[3:2] == 2'd2);
  assign unused_bits = ^{bus.addr_i[1:0], bus.wdata_i[31:N_SRC]};

  assign masked = pending_q & enable_q;
  assign active = |masked;
  assign sw_clr = wr_pending ? bus.wdata_i[N_SRC-1:0] : '0;

  // Lowest index wins, so scan downward and let later hits override.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) win = 5'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    claim_clr  = '0;
    case (state_q)
      IDLE: begin
        if (active) state_d = ASSERT;
      end
      ASSERT: begin
        if (bus.ack_i) begin
          if (active) begin
            claim_clr  = N_SRC'(1) << win;
            claim_id_d = win + 5'd1;
            state_d    = CLAIMED;
          end else begin
            claim_id_d = 5'd0;
            state_d    = IDLE;
          end
        end else if (!active) begin
          state_d = IDLE;
        end
      end
      CLAIMED: begin
        if (wr_claim) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge wins over a same-cycle software or claim clear of that bit.
  assign pending_d = (pending_q & ~sw_clr & ~claim_clr) | (bus.irq_i & ~irq_prev_q);

  always_comb begin
    rd_mux = 32'd0;
    case (bus.addr_i[3:2])
      2'd0:    rd_mux = 32'(enable_q);
      2'd1:    rd_mux = 32'(pending_q);
      2'd2:    rd_mux = {state_q == CLAIMED, 26'd0, claim_id_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      enable_q    <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      claim_id_q  <= 5'd0;
      bus.meip_o  <= 1'b0;
      bus.rdata_o <= 32'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= bus.irq_i;
      claim_id_q <= claim_id_d;
      bus.meip_o <= (state_q == ASSERT);
      if (wr_enable) enable_q <= bus.wdata_i[N_SRC-1:0];
      if (bus.ren_i) bus.rdata_o <= rd_mux;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller
// Directed scenarios followed by random traffic against a behavioural model.
module tb_irq_controller;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_i;
  irq_controller_if #(.N_SRC(N)) bus();
  irq_controller #(.N_SRC(N)) dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;
  logic [31:0] exp_rd_q[$];
  logic        exp_meip_q[$];

  // Model: 0 idle, 1 request raised, 2 claimed.
  int       m_state;
  int       m_cid;
  logic [7:0] m_en, m_pend, m_prev;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: output seen with no expected value queued", name);
  endtask

  function automatic logic [31:0] model_read(logic [3:0] a);
    case (a[3:2])
      2'd0:    return {24'd0, m_en};
      2'd1:    return {24'd0, m_pend};
      2'd2:    return {(m_state == 2), 26'd0, 5'(m_cid)};
      default: return 32'd0;
    endcase
  endfunction

  // Predict the effect of the coming clock edge, queue expectations, advance to the next negedge.
  task automatic step(bit use_const = 1'b0, logic [31:0] cexp = 32'd0);
    if (reset_i) begin
      m_state = 0; m_cid = 0; m_en = '0; m_pend = '0; m_prev = '0;
      exp_meip_q.push_back(1'b0);
    end else begin
      int win = -1;
      int ns, nc;
      bit act;
      logic [7:0] np;
      logic [1:0] a;
      a = bus.addr_i[3:2];
      if (bus.ren_i) exp_rd_q.push_back(use_const ? cexp : model_read(bus.addr_i));
      act = (m_pend & m_en) != 8'd0;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
      np = m_pend;
      if (bus.wen_i && a == 2'd1) np = np & ~bus.wdata_i[7:0];
      ns = m_state;
      nc = m_cid;
      case (m_state)
        0: if (act) ns = 1;
        1: begin
          if (bus.ack_i) begin
            if (act) begin np[win] = 1'b0; nc = win + 1; ns = 2; end
            else begin nc = 0; ns = 0; end
          end else if (!act) ns = 0;
        end
        default: if (bus.wen_i && a == 2'd2) ns = 0;
      endcase
      np = np | (bus.irq_i & ~m_prev);
      exp_meip_q.push_back(m_state == 1);
      if (bus.wen_i && a == 2'd0) m_en = bus.wdata_i[7:0];
      m_pend = np; m_prev = bus.irq_i; m_state = ns; m_cid = nc;
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    bus.wen_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
    step();
    bus.wen_i = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, logic [31:0] e);
    bus.ren_i = 1'b1; bus.addr_i = a;
    step(1'b1, e);
    bus.ren_i = 1'b0;
  endtask

  task automatic ack();
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
  endtask

  initial begin : monitor
    bit rv;
    forever begin
      @(posedge clk);
      if (!done) begin
        rv = bus.ren_i;
        #1;
        if (exp_meip_q.size() == 0) fail_now("meip_q");
        else chk("meip", 32'(bus.meip_o), 32'(exp_meip_q.pop_front()));
        if (rv) begin
          if (exp_rd_q.size() == 0) fail_now("rdata_q");
          else chk("rdata", bus.rdata_o, exp_rd_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    bus.irq_i = 8'hFF; bus.ack_i = 1'b0; bus.addr_i = 4'd0;
    bus.wdata_i = 32'd0; bus.wen_i = 1'b0; bus.ren_i = 1'b0;
    reset_i = 1'b1;

    // Reset with all lines high; only post-reset edges may latch.
    step(); step();
    chk("rst_meip", 32'(bus.meip_o), 32'd0);
    bus.irq_i = 8'h00;
    step();
    reset_i = 1'b0;
    rd(4'h0, 32'h0); rd(4'h4, 32'h0); rd(4'h8, 32'h0); rd(4'hC, 32'h0);
    bus.irq_i = 8'h40; step(); bus.irq_i = 8'h00; step();
    rd(4'h4, 32'h40);
    wr(4'h4, 32'h40);

    // Single source: latency, claim, completion.
    wr(4'h0, 32'h04);
    bus.irq_i = 8'h04; step(); bus.irq_i = 8'h00; step();
    chk("lat_meip_e2", 32'(bus.meip_o), 32'd0);
    step();
    chk("lat_meip_e3", 32'(bus.meip_o), 32'd1);
    ack();
    chk("ack_extra_cycle", 32'(bus.meip_o), 32'd1);
    step();
    chk("ack_meip_low", 32'(bus.meip_o), 32'd0);
    rd(4'h8, 32'h8000_0003);
    rd(4'h4, 32'h0);
    wr(4'h8, 32'h0);
    rd(4'h8, 32'h0000_0003);

    // Two simultaneous sources: priority, then reassert after completion.
    wr(4'h0, 32'hFF);
    bus.irq_i = 8'h22; step(); bus.irq_i = 8'h00; step(); step();
    chk("two_src_meip", 32'(bus.meip_o), 32'd1);
    ack(); step();
    rd(4'h8, 32'h8000_0002);
    wr(4'h8, 32'h0);
    chk("cmpl_meip_k", 32'(bus.meip_o), 32'd0);
    step();
    chk("cmpl_meip_k1", 32'(bus.meip_o), 32'd0);
    step();
    chk("cmpl_meip_k2", 32'(bus.meip_o), 32'd1);
    ack(); step();
    rd(4'h8, 32'h8000_0006);
    wr(4'h8, 32'h0);

    // Disabled source latches silently; enabling it raises the request.
    wr(4'h0, 32'h00);
    bus.irq_i = 8'h08; step(); bus.irq_i = 8'h00;
    idle(4);
    chk("disabled_meip", 32'(bus.meip_o), 32'd0);
    wr(4'h0, 32'h08);
    chk("en_meip_w", 32'(bus.meip_o), 32'd0);
    step();
    chk("en_meip_w1", 32'(bus.meip_o), 32'd0);
    step();
    chk("en_meip_w2", 32'(bus.meip_o), 32'd1);

    // Reset mid-request drops meip without waiting for a clock.
    reset_i = 1'b1;
    #1;
    chk("async_rst_meip", 32'(bus.meip_o), 32'd0);
    step(); step();
    reset_i = 1'b0;
    rd(4'h0, 32'h0); rd(4'h4, 32'h0); rd(4'h8, 32'h0);

    // Software clears everything while requesting; a late ack is ignored.
    wr(4'h0, 32'h08);
    bus.irq_i = 8'h08; step(); bus.irq_i = 8'h00; step(); step();
    chk("w1c_pre_meip", 32'(bus.meip_o), 32'd1);
    wr(4'h4, 32'hFF);
    step(); step();
    chk("w1c_meip_drop", 32'(bus.meip_o), 32'd0);
    ack();
    rd(4'h8, 32'h0);
    chk("late_ack_meip", 32'(bus.meip_o), 32'd0);

    // Edge and W1C on the same bit in the same cycle: the edge wins.
    bus.irq_i = 8'h01; bus.wen_i = 1'b1; bus.addr_i = 4'h4; bus.wdata_i = 32'h01;
    step();
    bus.wen_i = 1'b0; bus.irq_i = 8'h00;
    step();
    rd(4'h4, 32'h01);
    wr(4'h4, 32'h01);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.irq_i   = bus.irq_i ^ 8'($urandom & $urandom & $urandom);
      bus.ack_i   = ($urandom_range(0, 5) == 0);
      reset_i     = ($urandom_range(0, 699) == 0);
      bus.ren_i   = !reset_i && ($urandom_range(0, 2) == 0);
      bus.wen_i   = !reset_i && ($urandom_range(0, 4) == 0);
      bus.addr_i  = 4'($urandom);
      bus.wdata_i = $urandom;
      step();
    end
    reset_i = 1'b0; bus.ack_i = 1'b0; bus.ren_i = 1'b0; bus.wen_i = 1'b0;
    done = 1'b1;

    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    chk("meip_queue_drained", 32'(exp_meip_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
